// File: rtl/updown_sweep_pkg.sv
// Shared definitions for the up/down sweep sequencer.
// Contents:
//   state_e            sequencer states IDLE / UP / DOWN
//   MODE_UP, MODE_DOWN direction encoding on the mode output
package updown_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter.sv
// WIDTH-bit synchronous up/down counter driven by the sweep sequencer.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-low reset (count clears to 0)
//   en        step the count by one in the direction given by mode
//   load      load load_val (takes priority over en)
//   load_val  value loaded when load is high
//   mode      step direction, MODE_UP / MODE_DOWN
//   out       current count
module updown_counter
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= '0;
    end else if (load) begin
      out_q <= load_val;
    end else if (en) begin
      out_q <= (mode == MODE_UP) ? out_q + WIDTH'(1) : out_q - WIDTH'(1);
    end
  end

  assign out = out_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer: drives the up/down counter lo->hi->lo for a programmed
// number of sweeps, with pause, abort, busy/done/err status.
// Build option: UPDOWN_SWEEP_CONT_EN makes sweeps==0 a valid start that
// runs continuously (sweep_cnt wraps) until stop, never raising done.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   start, stop, pause    host controls
//   lo_lim, hi_lim        sweep limits (latched on accepted start)
//   sweeps                number of lo->hi->lo sweeps (latched on start)
//   out, mode             count value and direction (1=up, 0=down)
//   busy                  high while in UP/DOWN
//   done, err             one-cycle completion / rejected-start pulses
//   sweep_cnt             completed sweeps of the current run
//
// state | meaning
// IDLE  | waiting for start; out/mode hold last values
// UP    | counting toward latched hi
// DOWN  | counting toward latched lo
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int SWEEP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [SWEEP_W-1:0] sweeps,
  output logic [WIDTH-1:0]   out,
  output logic               mode,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [SWEEP_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;

  logic               cnt_en, cnt_load, cnt_dir;
  logic               start_ok;
  logic               last_sweep;
  logic [SWEEP_W:0]   sweep_nxt;

  updown_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (cnt_en),
    .load     (cnt_load),
    .load_val (lo_lim),
    .mode     (cnt_dir),
    .out      (out)
  );

  // One extra bit so the compare against sweeps cannot alias on overflow.
  assign sweep_nxt = {1'b0, sweep_cnt_q} + (SWEEP_W + 1)'(1);

`ifdef UPDOWN_SWEEP_CONT_EN
  assign start_ok   = (lo_lim < hi_lim);
  // sweeps_q==0 means run forever, so the final-sweep compare never hits.
  assign last_sweep = (sweeps_q != '0) && (sweep_nxt == {1'b0, sweeps_q});
`else
  assign start_ok   = (lo_lim < hi_lim) && (sweeps != '0);
  assign last_sweep = (sweep_nxt == {1'b0, sweeps_q});
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_UP;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sweep_cnt_q <= '0;
      sweeps_q    <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sweep_cnt_q <= sweep_cnt_d;
      sweeps_q    <= sweeps_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
    end
  end

  // cnt_dir is the direction of this edge's step; at a turnaround it
  // differs from mode_q, which only changes as the step lands.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    sweep_cnt_d = sweep_cnt_q;
    sweeps_d    = sweeps_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    cnt_en      = 1'b0;
    cnt_load    = 1'b0;
    cnt_dir     = MODE_UP;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            lo_d        = lo_lim;
            hi_d        = hi_lim;
            sweeps_d    = sweeps;
            cnt_load    = 1'b1;
            mode_d      = MODE_UP;
            sweep_cnt_d = '0;
            state_d     = UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      UP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!pause) begin
          cnt_en = 1'b1;
          if (out == hi_q) begin
            cnt_dir = MODE_DOWN;
            mode_d  = MODE_DOWN;
            state_d = DOWN;
          end
        end
      end
      DOWN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!pause) begin
          if (out != lo_q) begin
            cnt_en  = 1'b1;
            cnt_dir = MODE_DOWN;
          end else if (last_sweep) begin
            sweep_cnt_d = sweep_nxt[SWEEP_W-1:0];
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            cnt_en      = 1'b1;
            cnt_dir     = MODE_UP;
            mode_d      = MODE_UP;
            sweep_cnt_d = sweep_nxt[SWEEP_W-1:0];
            state_d     = UP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    mode      = mode_q;
    done      = done_q;
    err       = err_q;
    sweep_cnt = sweep_cnt_q;
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
module tb_updown_sweep_ctrl;

  localparam int W  = 3;
  localparam int SW = 4;

  typedef struct {
    logic [W-1:0]  out;
    logic          mode;
    logic          busy;
    logic          done;
    logic          err;
    logic [SW-1:0] sc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, stop, pause;
  logic [W-1:0]  lo_lim, hi_lim;
  logic [SW-1:0] sweeps;
  logic [W-1:0]  out;
  logic          mode, busy, done, err;
  logic [SW-1:0] sweep_cnt;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  updown_sweep_ctrl #(.WIDTH(W), .SWEEP_W(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .lo_lim    (lo_lim),
    .hi_lim    (hi_lim),
    .sweeps    (sweeps),
    .out       (out),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sweep_cnt (sweep_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int o, input int m, input int b, input int d, input int e, input int sc);
    exp_t x;
    x.out  = W'(o);
    x.mode = m[0];
    x.busy = b[0];
    x.done = d[0];
    x.err  = e[0];
    x.sc   = SW'(sc);
    sb.push_back(x);
  endtask

  // Advance one edge, then compare the DUT against the oldest expectation.
  task automatic cycle(input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 8'd1, 8'd0);
    end else begin
      x = sb.pop_front();
      chk({tag, "_out"},  {5'd0, out},       {5'd0, x.out});
      chk({tag, "_mode"}, {7'd0, mode},      {7'd0, x.mode});
      chk({tag, "_busy"}, {7'd0, busy},      {7'd0, x.busy});
      chk({tag, "_done"}, {7'd0, done},      {7'd0, x.done});
      chk({tag, "_err"},  {7'd0, err},       {7'd0, x.err});
      chk({tag, "_sc"},   {4'd0, sweep_cnt}, {4'd0, x.sc});
    end
  endtask

  task automatic drain(input string tag);
    while (sb.size() != 0) cycle(tag);
  endtask

  // Expected trace after an accepted start, through done and one idle cycle.
  task automatic exp_sweeps(input int lo, input int hi, input int n);
    for (int s = 0; s < n; s++) begin
      for (int v = lo + 1; v <= hi; v++) push(v, 1, 1, 0, 0, s);
      for (int v = hi - 1; v >= lo; v--) push(v, 0, 1, 0, 0, s);
    end
    push(lo, 0, 0, 1, 0, n);
    push(lo, 0, 0, 0, 0, n);
  endtask

  task automatic do_start(input int lo, input int hi, input int n);
    lo_lim = W'(lo);
    hi_lim = W'(hi);
    sweeps = SW'(n);
    start  = 1'b1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    lo_lim = '0; hi_lim = '0; sweeps = '0;

    // reset state
    push(0, 1, 0, 0, 0, 0);
    push(0, 1, 0, 0, 0, 0);
    drain("reset");
    reset = 1'b1;
    push(0, 1, 0, 0, 0, 0);
    drain("idle");

    // single sweep lo=2 hi=5: done 7 edges after accept
    do_start(2, 5, 1);
    push(2, 1, 1, 0, 0, 0);
    cycle("s1_accept");
    start = 1'b0;
    exp_sweeps(2, 5, 1);
    drain("s1");

    // two full-range sweeps, no wrap at 0/7, done after 29 edges
    do_start(0, 7, 2);
    push(0, 1, 1, 0, 0, 0);
    cycle("s2_accept");
    start = 1'b0;
    exp_sweeps(0, 7, 2);
    drain("s2");

    // rejected starts: lo==hi and lo>hi; out/mode/sweep_cnt unchanged
    do_start(5, 5, 1);
    push(0, 0, 0, 0, 1, 2);
    cycle("bad_eq");
    do_start(6, 2, 1);
    push(0, 0, 0, 0, 1, 2);
    cycle("bad_gt");
    start = 1'b0;
    push(0, 0, 0, 0, 0, 2);
    cycle("bad_clr");

    // sweeps==0
    do_start(1, 3, 0);
`ifdef UPDOWN_SWEEP_CONT_EN
    push(1, 1, 1, 0, 0, 0);
    cycle("cont_accept");
    start = 1'b0;
    push(2, 1, 1, 0, 0, 0);
    push(3, 1, 1, 0, 0, 0);
    push(2, 0, 1, 0, 0, 0);
    push(1, 0, 1, 0, 0, 0);
    push(2, 1, 1, 0, 0, 1);
    push(3, 1, 1, 0, 0, 1);
    drain("cont");
    stop = 1'b1;
    push(3, 1, 0, 0, 0, 1);
    cycle("cont_stop");
    stop = 1'b0;
    push(3, 1, 0, 0, 0, 1);
    cycle("cont_idle");
`else
    push(0, 0, 0, 0, 1, 2);
    cycle("zero_sweeps");
    start = 1'b0;
    push(0, 0, 0, 0, 0, 2);
    cycle("zero_clr");
`endif

    // pause at out=4 going up, then stop+pause together
    do_start(1, 6, 3);
    push(1, 1, 1, 0, 0, 0);
    cycle("ps_accept");
    start = 1'b0;
    push(2, 1, 1, 0, 0, 0);
    push(3, 1, 1, 0, 0, 0);
    push(4, 1, 1, 0, 0, 0);
    drain("ps_up");
    pause = 1'b1;
    push(4, 1, 1, 0, 0, 0);
    push(4, 1, 1, 0, 0, 0);
    push(4, 1, 1, 0, 0, 0);
    drain("ps_pause");
    pause = 1'b0;
    push(5, 1, 1, 0, 0, 0);
    push(6, 1, 1, 0, 0, 0);
    push(5, 0, 1, 0, 0, 0);
    drain("ps_resume");
    stop = 1'b1; pause = 1'b1;
    push(5, 0, 0, 0, 0, 0);
    cycle("ps_stop");
    stop = 1'b0; pause = 1'b0;
    push(5, 0, 0, 0, 0, 0);
    push(5, 0, 0, 0, 0, 0);
    drain("ps_idle");

    // start while busy is ignored, new limits not picked up
    do_start(2, 4, 1);
    push(2, 1, 1, 0, 0, 0);
    cycle("bs_accept");
    do_start(0, 7, 5);
    push(3, 1, 1, 0, 0, 0);
    cycle("bs_ignored");
    start = 1'b0;
    push(4, 1, 1, 0, 0, 0);
    push(3, 0, 1, 0, 0, 0);
    push(2, 0, 1, 0, 0, 0);
    push(2, 0, 0, 1, 0, 1);
    push(2, 0, 0, 0, 0, 1);
    drain("bs");

    // start + stop in IDLE: start wins
    do_start(0, 2, 1);
    stop = 1'b1;
    push(0, 1, 1, 0, 0, 0);
    cycle("ss_accept");
    start = 1'b0; stop = 1'b0;
    exp_sweeps(0, 2, 1);
    drain("ss");

    // reset for 2 cycles mid-sweep: no done afterwards
    do_start(2, 5, 1);
    push(2, 1, 1, 0, 0, 0);
    cycle("rs_accept");
    start = 1'b0;
    push(3, 1, 1, 0, 0, 0);
    push(4, 1, 1, 0, 0, 0);
    drain("rs_run");
    reset = 1'b0;
    push(0, 1, 0, 0, 0, 0);
    push(0, 1, 0, 0, 0, 0);
    drain("rs_reset");
    reset = 1'b1;
    push(0, 1, 0, 0, 0, 0);
    push(0, 1, 0, 0, 0, 0);
    push(0, 1, 0, 0, 0, 0);
    drain("rs_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer for the team's WIDTH-bit synchronous up/down counter.
- Host programs lower/upper limits and a sweep count, then pulses start.
- Block sweeps the count lo->hi->lo the requested number of times, driving direction (mode) and count value.
- Supports pause and abort; reports busy/done/err; sits between a host control register block and the counter consumer.

Parameters:
WIDTH, 3, counter/limit width in bits
SWEEP_W, 4, width of sweep count and sweep progress counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
start  input  1  begin sequence (sampled only in IDLE)
stop  input  1  abort active sequence
pause  input  1  freeze count and state while high
lo_lim  input  WIDTH  lower sweep limit
hi_lim  input  WIDTH  upper sweep limit
sweeps  input  SWEEP_W  number of lo->hi->lo sweeps
out  output  WIDTH  current count
mode  output  1  direction: 1=up, 0=down
busy  output  1  high in UP/DOWN
done  output  1  one-cycle pulse on normal completion
err  output  1  one-cycle pulse on rejected start
sweep_cnt  output  SWEEP_W  completed sweeps of current run

Behaviour:
- Reset (reset==0 at posedge clk): state=IDLE, out=0, mode=1, busy=0, done=0, err=0, sweep_cnt=0. Applies mid-sequence; no completion pulse.
- done/err default to 0 every cycle unless set below.
- FSM states: IDLE, UP, DOWN.
- IDLE:
  - start=1 with lo_lim>=hi_lim or sweeps==0: err=1 for one cycle, stay IDLE, out/mode unchanged.
  - start=1 and valid: latch lo/hi/sweeps internally; out<=lo_lim, mode<=1, sweep_cnt<=0, busy<=1, state<=UP.
  - stop and pause are ignored; start wins over a simultaneous stop.
- Priority in UP/DOWN: stop > pause > count. start is ignored while busy; limit inputs are not re-sampled.
- stop: state<=IDLE, busy<=0; out, mode and sweep_cnt hold; no done.
- pause=1: out, mode, state and sweep_cnt hold.
- UP:
  - out!=hi: out<=out+1.
  - out==hi: out<=hi-1, mode<=0, state<=DOWN.
- DOWN:
  - out!=lo: out<=out-1.
  - out==lo, sweep_cnt+1<sweeps: sweep_cnt<=sweep_cnt+1, out<=lo+1, mode<=1, state<=UP.
  - out==lo, sweep_cnt+1==sweeps: sweep_cnt<=sweeps, state<=IDLE, busy<=0, done<=1; out holds lo, mode stays 0.
- Timing: one sweep takes 2*(hi-lo) count edges. done rises 2*(hi-lo)*sweeps+1 edges after the start-accept edge (no pause).
- Arithmetic: unsigned. Limits are compared on latched values, so out never wraps past 0 or 2^WIDTH-1. hi=2^WIDTH-1 and lo=0 are legal.

Optional Feature:
- Macro: UPDOWN_SWEEP_CONT_EN.
- Defined: sweeps==0 is a valid start meaning continuous run. sweep_cnt increments and wraps modulo 2^SWEEP_W; the block runs until stop and never asserts done.
- Undefined: sweeps==0 raises err as above.

Decomposition:
- Package updown_sweep_pkg: state enum typedef (IDLE/UP/DOWN), direction constants MODE_UP=1/MODE_DOWN=0.
- Sub-module updown_counter (WIDTH param; en, load, load_val, mode in; out reg) holds the count.
- updown_sweep_ctrl owns the FSM, limit/sweep latches and the load/en/mode sequencing.

Test Plan:
- Reset: reset=0 for 2 cycles mid-sweep -> out=0, mode=1, busy=0, sweep_cnt=0; no done.
- Single sweep, lo=2 hi=5 sweeps=1:
  - out per edge 2,3,4,5,4,3,2; mode falls on the edge out becomes 4.
  - done=1 exactly one cycle, 7 edges after accept; busy=0; out holds 2.
- Two sweeps, full range lo=0 hi=7 sweeps=2 -> out 0..7..0..7..0, sweep_cnt 0->1->2, done after 29 edges, no wrap to 7/0 at the extremes.
- Bad start, lo=5 hi=5 -> err single-cycle pulse, busy stays 0. Separately sweeps=0 -> err (macro undefined) or continuous run (macro defined, stopped by stop).
- Pause/stop, lo=1 hi=6 sweeps=3:
  - pause for 3 cycles at out=4 going up -> out stays 4, mode stays 1, resumes at 5.
  - stop and pause together -> IDLE next edge, out holds, no done.
- start while busy and start+stop in IDLE: busy start ignored (limits unchanged); idle start+stop -> sequence begins.
